bist_wrapper_mc: RTL and testbench

Parametrised built-in-self-test wrapper placed between chip pads and an arbitrary pipelined DUT (CORDIC, MAC array, etc.). It generates stimulus from an internal Galois LFSR or forwards external stimulus, and forwards DUT results directly or compresses them in a MISR. A control FSM runs a programmed number of patterns, drains the DUT pipeline, and reports pass/fail against a golden signature.

---
 rtl/bist_wrapper_mc.sv | 215 +++++++++++++++++++++
 tb/tb_bist_wrapper_mc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_wrapper_mc.sv
// Built-in self-test wrapper: LFSR or external stimulus towards a pipelined DUT,
// direct or MISR-compressed result path, and a run FSM that checks a golden signature.
module bist_wrapper_mc #(
  parameter int                   IN_WIDTH     = 49,
  parameter int                   OUT_WIDTH    = 54,
  parameter int                   CNT_WIDTH    = 16,
  parameter int                   DRAIN_CYCLES = 16,
  parameter logic [IN_WIDTH-1:0]  LFSR_POLY    = {{(IN_WIDTH-1){1'b0}}, 1'b1},
  parameter logic [OUT_WIDTH-1:0] MISR_POLY    = {{(OUT_WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                 i_clk,
  input  logic                 i_async_rst_n,
  input  logic [1:0]           i_mode,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_num_patterns,
  input  logic                 i_seed_vld,
  input  logic [IN_WIDTH-1:0]  i_seed_data,
  input  logic [OUT_WIDTH-1:0] i_golden_sig,
  input  logic                 i_vld,
  input  logic [IN_WIDTH-1:0]  i_data,
  output logic                 o_dut_vld,
  output logic [IN_WIDTH-1:0]  o_dut_data,
  input  logic                 i_dut_vld,
  input  logic [OUT_WIDTH-1:0] i_dut_data,
  output logic                 o_vld,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [CNT_WIDTH-1:0] o_pattern_cnt,
  output logic                 o_sample_clk
);

  localparam int                  DW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]       DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [IN_WIDTH-1:0] SEED_ONE   = {{(IN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_DRAIN,
    S_DONE
  } state_e;

  // mode bit 1 selects LFSR stimulus, bit 0 selects MISR compression
  localparam int MODE_LFSR = 1;
  localparam int MODE_MISR = 0;

  function automatic logic [IN_WIDTH-1:0] lfsr_step(input logic [IN_WIDTH-1:0] l);
    return {l[IN_WIDTH-2:0], 1'b0} ^ (l[IN_WIDTH-1] ? LFSR_POLY : '0);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] misr_step(input logic [OUT_WIDTH-1:0] s);
    return {s[OUT_WIDTH-2:0], 1'b0} ^ (s[OUT_WIDTH-1] ? MISR_POLY : '0);
  endfunction

  // Reset asserts immediately; release is synchronised so no flop leaves reset
  // on a different edge than its neighbours.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) rst_sync_q <= 2'b00;
    else                rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_e                 state_q,    state_d;
  logic [1:0]             mode_q,     mode_d;
  logic [CNT_WIDTH-1:0]   num_q,      num_d;
  logic [OUT_WIDTH-1:0]   golden_q,   golden_d;
  logic [IN_WIDTH-1:0]    seed_q,     seed_d;
  logic [IN_WIDTH-1:0]    lfsr_q,     lfsr_d;
  logic [CNT_WIDTH-1:0]   cnt_q,      cnt_d;
  logic [DW-1:0]          drain_q,    drain_d;
  logic [OUT_WIDTH-1:0]   misr_q,     misr_d;
  logic                   dut_vld_q,  dut_vld_d;
  logic [IN_WIDTH-1:0]    dut_data_q, dut_data_d;
  logic                   vld_q,      vld_d;
  logic [OUT_WIDTH-1:0]   data_q,     data_d;
  logic                   pass_q,     pass_d;

  // NOTE: every variable gets a default before any branch so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    num_d      = num_q;
    golden_d   = golden_q;
    seed_d     = seed_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    misr_d     = misr_q;
    dut_vld_d  = 1'b0;
    dut_data_d = dut_data_q;
    vld_d      = 1'b0;
    data_d     = data_q;
    pass_d     = pass_q;

    if (!mode_q[MODE_MISR]) begin
      vld_d  = i_dut_vld;
      data_d = i_dut_data;
    end

    if ((state_q == S_GEN || state_q == S_DRAIN) && i_dut_vld) begin
      misr_d = misr_step(misr_q) ^ i_dut_data;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_seed_vld) seed_d = (i_seed_data == '0) ? SEED_ONE : i_seed_data;
        if (i_start) begin
          mode_d   = i_mode;
          num_d    = i_num_patterns;
          golden_d = i_golden_sig;
          cnt_d    = '0;
          drain_d  = '0;
          misr_d   = '0;
          pass_d   = 1'b0;
          if (i_num_patterns == '0) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_GEN;
            // The seed leaves on the start edge so patterns appear from t+1.
            if (i_mode[MODE_LFSR]) begin
              dut_vld_d  = 1'b1;
              dut_data_d = seed_q;
              lfsr_d     = lfsr_step(seed_q);
              cnt_d      = CNT_WIDTH'(1);
            end
          end
        end
      end

      S_GEN: begin
        if (cnt_q == num_q) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (mode_q[MODE_LFSR]) begin
          dut_vld_d  = 1'b1;
          dut_data_d = lfsr_q;
          lfsr_d     = lfsr_step(lfsr_q);
          cnt_d      = cnt_q + CNT_WIDTH'(1);
        end else if (i_vld) begin
          dut_vld_d  = 1'b1;
          dut_data_d = i_data;
          cnt_d      = cnt_q + CNT_WIDTH'(1);
        end
      end

      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
          // Signature includes any result arriving on the final drain cycle.
          if (mode_q[MODE_MISR]) begin
            vld_d  = 1'b1;
            data_d = misr_d;
            pass_d = (misr_d == golden_q);
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      num_q      <= '0;
      golden_q   <= '0;
      seed_q     <= SEED_ONE;
      lfsr_q     <= SEED_ONE;
      cnt_q      <= '0;
      drain_q    <= '0;
      misr_q     <= '0;
      dut_vld_q  <= 1'b0;
      dut_data_q <= '0;
      vld_q      <= 1'b0;
      data_q     <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      num_q      <= num_d;
      golden_q   <= golden_d;
      seed_q     <= seed_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      misr_q     <= misr_d;
      dut_vld_q  <= dut_vld_d;
      dut_data_q <= dut_data_d;
      vld_q      <= vld_d;
      data_q     <= data_d;
      pass_q     <= pass_d;
    end
  end

  assign o_dut_vld     = dut_vld_q;
  assign o_dut_data    = dut_data_q;
  assign o_vld         = vld_q;
  assign o_data        = data_q;
  assign o_busy        = (state_q == S_GEN) || (state_q == S_DRAIN);
  assign o_done        = (state_q == S_DONE);
  assign o_pass        = pass_q;
  assign o_pattern_cnt = cnt_q;
  assign o_sample_clk  = i_clk;

endmodule

// File: tb/tb_bist_wrapper_mc.sv
// Scoreboard bench for bist_wrapper_mc: 8-bit datapath with the DUT replaced
// by a combinational loopback, directed runs with hand-computed expectations.
module tb_bist_wrapper_mc;

  localparam int W  = 8;
  localparam int CW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    i_mode = '0;
  logic          i_start = 1'b0;
  logic [CW-1:0] i_num_patterns = '0;
  logic          i_seed_vld = 1'b0;
  logic [W-1:0]  i_seed_data = '0;
  logic [W-1:0]  i_golden_sig = '0;
  logic          i_vld = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          o_dut_vld;
  logic [W-1:0]  o_dut_data;
  logic          i_dut_vld;
  logic [W-1:0]  i_dut_data;
  logic          o_vld;
  logic [W-1:0]  o_data;
  logic          o_busy, o_done, o_pass;
  logic [CW-1:0] o_pattern_cnt;
  logic          o_sample_clk;

  assign i_dut_vld  = o_dut_vld;
  assign i_dut_data = o_dut_data;

  bist_wrapper_mc #(
    .IN_WIDTH(W), .OUT_WIDTH(W), .CNT_WIDTH(CW), .DRAIN_CYCLES(D),
    .LFSR_POLY(8'h1D), .MISR_POLY(8'h1D)
  ) dut (
    .i_clk(clk), .i_async_rst_n(rst_n), .i_mode(i_mode), .i_start(i_start),
    .i_num_patterns(i_num_patterns), .i_seed_vld(i_seed_vld), .i_seed_data(i_seed_data),
    .i_golden_sig(i_golden_sig), .i_vld(i_vld), .i_data(i_data),
    .o_dut_vld(o_dut_vld), .o_dut_data(o_dut_data),
    .i_dut_vld(i_dut_vld), .i_dut_data(i_dut_data),
    .o_vld(o_vld), .o_data(o_data), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_pattern_cnt(o_pattern_cnt), .o_sample_clk(o_sample_clk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         pass;
    logic         done;
  } exp_out_t;

  logic [W-1:0] exp_dut_q[$];
  exp_out_t     exp_out_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever either output stream presents a beat.
  always @(negedge clk) begin
    if (o_dut_vld) begin
      if (exp_dut_q.size() == 0) check("dut_vld_unexpected", o_dut_vld, 0);
      else check("dut_data", o_dut_data, exp_dut_q.pop_front());
    end
    if (o_vld) begin
      if (exp_out_q.size() == 0) begin
        check("out_vld_unexpected", o_vld, 0);
      end else begin
        exp_out_t e;
        e = exp_out_q.pop_front();
        check("out_data", o_data, e.data);
        check("out_pass", o_pass, e.pass);
        check("out_done", o_done, e.done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [W-1:0] s);
    i_seed_vld  = 1'b1;
    i_seed_data = s;
    tick();
    i_seed_vld  = 1'b0;
  endtask

  task automatic start_run(input logic [1:0] mode, input logic [CW-1:0] n, input logic [W-1:0] g);
    i_mode         = mode;
    i_num_patterns = n;
    i_golden_sig   = g;
    i_start        = 1'b1;
    tick();
    i_start        = 1'b0;
  endtask

  // Counts cycles from the current one until o_done; bounded.
  task automatic wait_done(input string name, input int exp_cycles);
    int n = 0;
    while (!o_done && n < 200) begin
      tick();
      n++;
    end
    check(name, n, exp_cycles);
  endtask

  task automatic push_out(input logic [W-1:0] d, input logic p, input logic dn);
    exp_out_t e;
    e.data = d; e.pass = p; e.done = dn;
    exp_out_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   o_busy, 0);
    check({tag, "_done"},   o_done, 0);
    check({tag, "_pass"},   o_pass, 0);
    check({tag, "_vld"},    o_vld, 0);
    check({tag, "_data"},   o_data, 0);
    check({tag, "_dutvld"}, o_dut_vld, 0);
    check({tag, "_dutdat"}, o_dut_data, 0);
    check({tag, "_cnt"},    o_pattern_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    #10 rst_n = 1'b1;
    repeat (3) tick();

    // LFSR + direct, seed 80, N=2: patterns 80, 1D forwarded back one cycle later
    load_seed(8'h80);
    exp_dut_q.push_back(8'h80);
    exp_dut_q.push_back(8'h1D);
    push_out(8'h80, 1'b0, 1'b0);
    push_out(8'h1D, 1'b0, 1'b0);
    start_run(2'b10, 8'd2, 8'h00);
    check("t1_busy_at_t1", o_busy, 1);
    wait_done("t1_done_latency", 2 + D);
    check("t1_cnt", o_pattern_cnt, 2);
    check("t1_pass_direct", o_pass, 0);
    repeat (2) tick();

    // LFSR + MISR, seed 01, N=3: patterns 01,02,04, signature 04, golden matches
    load_seed(8'h01);
    exp_dut_q.push_back(8'h01);
    exp_dut_q.push_back(8'h02);
    exp_dut_q.push_back(8'h04);
    push_out(8'h04, 1'b1, 1'b1);
    start_run(2'b11, 8'd3, 8'h04);
    check("t2_done_cleared", o_done, 0);
    wait_done("t2_done_latency", 3 + D);
    check("t2_cnt_sat", o_pattern_cnt, 3);
    repeat (3) tick();
    check("t2_pass_held", o_pass, 1);
    check("t2_sig_held", o_data, 8'h04);
    check("t2_busy_low", o_busy, 0);

    // Same run restarted from DONE with a wrong golden value
    exp_dut_q.push_back(8'h01);
    exp_dut_q.push_back(8'h02);
    exp_dut_q.push_back(8'h04);
    push_out(8'h04, 1'b0, 1'b1);
    start_run(2'b11, 8'd3, 8'h05);
    check("t3_pass_cleared", o_pass, 0);
    wait_done("t3_done_latency", 3 + D);
    repeat (2) tick();
    check("t3_pass_low", o_pass, 0);

    // N=0: no stimulus, straight to drain, empty signature
    push_out(8'h00, 1'b1, 1'b1);
    start_run(2'b11, 8'd0, 8'h00);
    check("t4_busy", o_busy, 1);
    wait_done("t4_done_latency", D);
    check("t4_cnt", o_pattern_cnt, 0);
    repeat (2) tick();

    // Reset in the middle of GEN aborts everything at once
    load_seed(8'h55);
    exp_dut_q.push_back(8'h55);
    exp_dut_q.push_back(8'hAA);
    start_run(2'b11, 8'd5, 8'h00);
    tick();
    @(negedge clk);
    #1;
    check("t5_cnt_before_rst", o_pattern_cnt, 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    #10 rst_n = 1'b1;
    repeat (3) tick();
    check("t5_idle_after_rst", o_busy, 0);
    // Seed register is back at 01
    exp_dut_q.push_back(8'h01);
    push_out(8'h01, 1'b0, 1'b0);
    start_run(2'b10, 8'd1, 8'h00);
    wait_done("t5_done_latency", 1 + D);
    repeat (2) tick();

    // External + direct: 3 beats with a gap, stray start and a surplus beat
    exp_dut_q.push_back(8'hA1);
    exp_dut_q.push_back(8'hA2);
    exp_dut_q.push_back(8'hA3);
    push_out(8'hA1, 1'b0, 1'b0);
    push_out(8'hA2, 1'b0, 1'b0);
    push_out(8'hA3, 1'b0, 1'b0);
    start_run(2'b00, 8'd3, 8'h00);
    check("t6_no_stim_yet", o_dut_vld, 0);
    i_vld = 1'b1; i_data = 8'hA1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("t6_latency_vld", o_dut_vld, 1);
    check("t6_latency_data", o_dut_data, 8'hA1);
    i_vld = 1'b0;
    tick();
    check("t6_gap", o_dut_vld, 0);
    check("t6_start_ignored", o_pattern_cnt, 1);
    i_vld = 1'b1; i_data = 8'hA2;
    tick();
    i_data = 8'hA3;
    tick();
    i_data = 8'hA4;
    tick();
    i_vld = 1'b0;
    check("t6_cnt_sat", o_pattern_cnt, 3);
    wait_done("t6_done_latency", D);
    check("t6_pass_direct", o_pass, 0);
    repeat (3) tick();

    check("exp_dut_drained", exp_dut_q.size(), 0);
    check("exp_out_drained", exp_out_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
